// File: rtl/step_regfile.sv
`default_nettype none
// ============================================================================
// Module   : step_regfile
// Purpose  : Small register file with one write port, two combinational read
//            ports and one increment/decrement ("step") port. A registered
//            carry flag reports whether the last applied step wrapped.
//
// Parameters
//   WIDTH        register width in bits (1..32)
//   DEPTH        number of registers (2..16, need not be a power of two)
//   AW           address width, fixed to $clog2(DEPTH)
//
// Ports
//   clk          clock; all state changes on its rising edge
//   reset        synchronous active-high reset; clears registers and carry
//   write_enable write strobe
//   write_addr   register to write
//   write_data   value to write
//   read_addr_a  read port A address
//   read_addr_b  read port B address
//   read_data_a  read port A data (combinational)
//   read_data_b  read port B data (combinational)
//   step_enable  step strobe
//   step_addr    register to step
//   step_down    0 = add one, 1 = subtract one (modulo 2^WIDTH)
//   step_carry   1 for the cycle after an applied step that wrapped
//
// Build option
//   STEP_REGFILE_BYPASS_EN  when defined, a read whose address matches an
//                           in-range active write returns write_data in the
//                           same cycle. Step results are never forwarded.
//
// Revision : 1.0  initial release
// ============================================================================
module step_regfile #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_addr_a,
    input  logic [AW-1:0]    read_addr_b,
    output logic [WIDTH-1:0] read_data_a,
    output logic [WIDTH-1:0] read_data_b,
    input  logic             step_enable,
    input  logic [AW-1:0]    step_addr,
    input  logic             step_down,
    output logic             step_carry
);

    // DEPTH widened by one bit so that an address can be compared against it
    // even when DEPTH is an exact power of two.
    localparam logic [AW:0]      c_DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] c_ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             r_carry;

    logic             w_wr_ok;
    logic             w_step_in_range;
    logic             w_step_ok;
    logic             w_wrap;
    logic [WIDTH-1:0] w_step_cur;
    logic [WIDTH-1:0] w_step_nxt;

    assign w_wr_ok         = write_enable && ({1'b0, write_addr} < c_DEPTH_EXT);
    assign w_step_in_range = {1'b0, step_addr} < c_DEPTH_EXT;

    // A write to the same register takes priority and the step is dropped
    // entirely, including its carry.
    assign w_step_ok = step_enable && w_step_in_range &&
                       !(w_wr_ok && (write_addr == step_addr));

    // Select the current value of the stepped register without indexing the
    // array with a possibly out-of-range address.
    always_comb begin
        w_step_cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (step_addr == AW'(i)) begin
                w_step_cur = r_regs[i];
            end
        end
    end

    assign w_step_nxt = step_down ? (w_step_cur - c_ONE) : (w_step_cur + c_ONE);
    assign w_wrap     = step_down ? (w_step_cur == '0) : (w_step_cur == c_ALL_ONES);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_carry <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_ok && (write_addr == AW'(i))) begin
                    r_regs[i] <= write_data;
                end else if (w_step_ok && (step_addr == AW'(i))) begin
                    r_regs[i] <= w_step_nxt;
                end
            end
            r_carry <= w_step_ok && w_wrap;
        end
    end

    assign step_carry = r_carry;

    // Out-of-range addresses match no register and therefore read as zero.
    always_comb begin
        read_data_a = '0;
        read_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read_addr_a == AW'(i)) begin
                read_data_a = r_regs[i];
            end
            if (read_addr_b == AW'(i)) begin
                read_data_b = r_regs[i];
            end
        end
`ifdef STEP_REGFILE_BYPASS_EN
        if (w_wr_ok && (read_addr_a == write_addr)) begin
            read_data_a = write_data;
        end
        if (w_wr_ok && (read_addr_b == write_addr)) begin
            read_data_b = write_data;
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_step_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_regfile
// Purpose  : Self-checking bench for step_regfile. Three instances cover the
//            default geometry (8x4), a non-power-of-two depth (8x3) and a
//            wider/deeper file (16x8). A behavioural model tracks register
//            contents and the carry flag; outputs are compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_step_regfile;

    localparam int NK = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    bit   chk_on = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    int unsigned we_i [NK];
    int unsigned wa_i [NK];
    int unsigned wd_i [NK];
    int unsigned ra_i [NK];
    int unsigned rb_i [NK];
    int unsigned se_i [NK];
    int unsigned sa_i [NK];
    int unsigned sd_i [NK];

    // ------------------------------------------------------------------ DUTs
    logic [7:0]  rda0, rdb0;
    logic        cy0;
    logic [7:0]  rda1, rdb1;
    logic        cy1;
    logic [15:0] rda2, rdb2;
    logic        cy2;

    step_regfile #(.WIDTH(8), .DEPTH(4)) u_dut0 (
        .clk(clk), .reset(rst),
        .write_enable(we_i[0][0]), .write_addr(wa_i[0][1:0]), .write_data(wd_i[0][7:0]),
        .read_addr_a(ra_i[0][1:0]), .read_addr_b(rb_i[0][1:0]),
        .read_data_a(rda0), .read_data_b(rdb0),
        .step_enable(se_i[0][0]), .step_addr(sa_i[0][1:0]), .step_down(sd_i[0][0]),
        .step_carry(cy0)
    );

    step_regfile #(.WIDTH(8), .DEPTH(3)) u_dut1 (
        .clk(clk), .reset(rst),
        .write_enable(we_i[1][0]), .write_addr(wa_i[1][1:0]), .write_data(wd_i[1][7:0]),
        .read_addr_a(ra_i[1][1:0]), .read_addr_b(rb_i[1][1:0]),
        .read_data_a(rda1), .read_data_b(rdb1),
        .step_enable(se_i[1][0]), .step_addr(sa_i[1][1:0]), .step_down(sd_i[1][0]),
        .step_carry(cy1)
    );

    step_regfile #(.WIDTH(16), .DEPTH(8)) u_dut2 (
        .clk(clk), .reset(rst),
        .write_enable(we_i[2][0]), .write_addr(wa_i[2][2:0]), .write_data(wd_i[2][15:0]),
        .read_addr_a(ra_i[2][2:0]), .read_addr_b(rb_i[2][2:0]),
        .read_data_a(rda2), .read_data_b(rdb2),
        .step_enable(se_i[2][0]), .step_addr(sa_i[2][2:0]), .step_down(sd_i[2][0]),
        .step_carry(cy2)
    );

    // ----------------------------------------------------------------- model
    int unsigned m_reg [NK][16];
    bit          m_cy  [NK];

    function automatic int unsigned dep(int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 8;
    endfunction

    function automatic int unsigned msk(int k);
        return (k == 2) ? 32'hFFFF : 32'hFF;
    endfunction

    function automatic int unsigned amax(int k);
        return (k == 2) ? 7 : 3;
    endfunction

    // Applies one rising edge worth of behaviour using the current inputs.
    task automatic model_step();
        for (int k = 0; k < NK; k++) begin
            bit          wok;
            bit          sok;
            int unsigned old;
            if (rst) begin
                for (int j = 0; j < 16; j++) m_reg[k][j] = 0;
                m_cy[k] = 1'b0;
            end else begin
                wok = (we_i[k] != 0) && (wa_i[k] < dep(k));
                sok = (se_i[k] != 0) && (sa_i[k] < dep(k)) && !(wok && (wa_i[k] == sa_i[k]));
                m_cy[k] = 1'b0;
                if (sok) begin
                    old = m_reg[k][sa_i[k]];
                    if (sd_i[k] != 0) begin
                        m_cy[k] = (old == 0);
                        m_reg[k][sa_i[k]] = (old + msk(k)) & msk(k);
                    end else begin
                        m_cy[k] = (old == msk(k));
                        m_reg[k][sa_i[k]] = (old + 1) & msk(k);
                    end
                end
                if (wok) m_reg[k][wa_i[k]] = wd_i[k] & msk(k);
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, int unsigned addr);
        if (addr >= dep(k)) return 32'd0;
`ifdef STEP_REGFILE_BYPASS_EN
        if ((we_i[k] != 0) && (wa_i[k] < dep(k)) && (wa_i[k] == addr)) return wd_i[k] & msk(k);
`endif
        return m_reg[k][addr];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ compare process
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("rd_a0", 32'(rda0), exp_rd(0, ra_i[0]));
                chk("rd_b0", 32'(rdb0), exp_rd(0, rb_i[0]));
                chk("cy0",   32'(cy0),  32'(m_cy[0]));
                chk("rd_a1", 32'(rda1), exp_rd(1, ra_i[1]));
                chk("rd_b1", 32'(rdb1), exp_rd(1, rb_i[1]));
                chk("cy1",   32'(cy1),  32'(m_cy[1]));
                chk("rd_a2", 32'(rda2), exp_rd(2, ra_i[2]));
                chk("rd_b2", 32'(rdb2), exp_rd(2, rb_i[2]));
                chk("cy2",   32'(cy2),  32'(m_cy[2]));
            end
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic idle();
        for (int k = 0; k < NK; k++) begin
            we_i[k] = 0; wa_i[k] = 0; wd_i[k] = 0; ra_i[k] = 0;
            rb_i[k] = 0; se_i[k] = 0; sa_i[k] = 0; sd_i[k] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] byp_exp;

        rst = 1'b1;
        idle();
        // Write during reset must be ignored.
        we_i[0] = 1; wa_i[0] = 1; wd_i[0] = 32'h5A;
        tick();
        tick();
        rst = 1'b0;
        idle();
        chk_on = 1'b1;

        // All addresses read zero after reset, carry clear.
        for (int a = 0; a < 4; a++) begin
            ra_i[0] = a; rb_i[0] = 3 - a;
            at_neg();
            chk("rst_rd_a", 32'(rda0), 32'h0);
            chk("rst_rd_b", 32'(rdb0), 32'h0);
            chk("rst_cy",   32'(cy0),  32'h0);
            tick();
        end

        // Wrap up from 0xFF, then wrap down from 0x00.
        we_i[0] = 1; wa_i[0] = 2; wd_i[0] = 32'hFF;
        tick();
        idle(); se_i[0] = 1; sa_i[0] = 2; sd_i[0] = 0;
        tick();
        idle(); ra_i[0] = 2;
        at_neg();
        chk("wrap_up_val",   32'(rda0), 32'h00);
        chk("wrap_up_cy",    32'(cy0),  32'h1);
        chk("model_wrap_up", m_reg[0][2], 32'h00);
        tick();
        at_neg();
        chk("cy_one_cycle", 32'(cy0), 32'h0);
        tick();
        se_i[0] = 1; sa_i[0] = 2; sd_i[0] = 1;
        tick();
        idle(); ra_i[0] = 2;
        at_neg();
        chk("wrap_dn_val", 32'(rda0), 32'hFF);
        chk("wrap_dn_cy",  32'(cy0),  32'h1);
        tick();

        // Write and step to the same register: write wins, no carry.
        we_i[0] = 1; wa_i[0] = 0; wd_i[0] = 32'h10;
        se_i[0] = 1; sa_i[0] = 0; sd_i[0] = 0;
        tick();
        idle(); ra_i[0] = 0;
        at_neg();
        chk("same_addr_val", 32'(rda0), 32'h10);
        chk("same_addr_cy",  32'(cy0),  32'h0);
        tick();

        // Write and step to different registers: both apply.
        we_i[0] = 1; wa_i[0] = 3; wd_i[0] = 32'h05;
        tick();
        we_i[0] = 1; wa_i[0] = 0; wd_i[0] = 32'h10;
        se_i[0] = 1; sa_i[0] = 3; sd_i[0] = 1;
        tick();
        idle(); ra_i[0] = 0; rb_i[0] = 3;
        at_neg();
        chk("diff_addr_wr",    32'(rda0), 32'h10);
        chk("diff_addr_step",  32'(rdb0), 32'h04);
        chk("model_diff_step", m_reg[0][3], 32'h04);
        tick();

        // Write-through visibility.
        we_i[0] = 1; wa_i[0] = 1; wd_i[0] = 32'h33; ra_i[0] = 1;
`ifdef STEP_REGFILE_BYPASS_EN
        byp_exp = 32'h33;
`else
        byp_exp = 32'h00;
`endif
        at_neg();
        chk("bypass_same_cycle", 32'(rda0), byp_exp);
        tick();
        idle(); ra_i[0] = 1;
        at_neg();
        chk("write_after_edge", 32'(rda0), 32'h33);
        tick();

        // DEPTH=3: address 3 is out of range for write, step and read.
        we_i[1] = 1; wa_i[1] = 3; wd_i[1] = 32'hAA; ra_i[1] = 3;
        at_neg();
        chk("oor_rd_bypass", 32'(rda1), 32'h0);
        tick();
        idle(); se_i[1] = 1; sa_i[1] = 3; sd_i[1] = 1;
        tick();
        idle(); ra_i[1] = 3;
        at_neg();
        chk("oor_rd",   32'(rda1), 32'h0);
        chk("oor_step_cy", 32'(cy1), 32'h0);
        tick();

        // WIDTH=16, DEPTH=8: wrap r7 from 0xFFFF.
        we_i[2] = 1; wa_i[2] = 7; wd_i[2] = 32'hFFFF;
        tick();
        idle(); se_i[2] = 1; sa_i[2] = 7; sd_i[2] = 0;
        tick();
        idle(); ra_i[2] = 7; rb_i[2] = 0;
        at_neg();
        chk("w16_wrap_val", 32'(rda2), 32'h0000);
        chk("w16_wrap_cy",  32'(cy2),  32'h1);
        chk("w16_other",    32'(rdb2), 32'h0000);
        tick();

        // Randomized phase, including occasional mid-sequence resets.
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < NK; k++) begin
                int unsigned sel;
                we_i[k] = $urandom_range(0, 1);
                wa_i[k] = $urandom_range(0, amax(k));
                sel     = $urandom_range(0, 3);
                wd_i[k] = (sel == 0) ? 0 : (sel == 1) ? msk(k) :
                          (sel == 2) ? msk(k) - 1 : ($urandom & msk(k));
                ra_i[k] = $urandom_range(0, amax(k));
                rb_i[k] = $urandom_range(0, amax(k));
                se_i[k] = $urandom_range(0, 1);
                sa_i[k] = $urandom_range(0, amax(k));
                sd_i[k] = $urandom_range(0, 1);
            end
            tick();
        end

        rst = 1'b0;
        idle();
        at_neg();
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
